// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace
// multiplier.
//
// Contents:
//   LATENCY         number of register stages between operand and result.
//   csa_rows_next   row count after one layer of 3:2 carry-save compression.
//   wallace_levels  number of 3:2 layers needed to bring N rows down to two.
//   wallace_rows_at row count present at the input of a given layer.
//   bw_const        Baugh-Wooley correction row for a given operand width.
package wallace_pkg;

  localparam int LATENCY   = 3;
  localparam int MAX_WIDTH = 32;

  // Every full group of three rows becomes a sum row and a carry row; the
  // leftover one or two rows pass straight through to the next layer.
  function automatic int csa_rows_next(input int rows);
    return 2 * (rows / 3) + (rows % 3);
  endfunction

  function automatic int wallace_levels(input int rows);
    int n;
    int lv;
    n  = rows;
    lv = 0;
    while (n > 2) begin
      n  = csa_rows_next(n);
      lv = lv + 1;
    end
    return lv;
  endfunction

  function automatic int wallace_rows_at(input int rows, input int level);
    int n;
    n = rows;
    for (int i = 0; i < level; i++) begin
      n = csa_rows_next(n);
    end
    return n;
  endfunction

  // Ones at columns width and 2*width-1. Added to the inverted sign terms,
  // this turns the unsigned array sum into the two's-complement product
  // modulo 2^(2*width).
  function automatic logic [2*MAX_WIDTH-1:0] bw_const(input int width);
    logic [2*MAX_WIDTH-1:0] c;
    c = '0;
    c[width]       = 1'b1;
    c[2*width-1]   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One row of full adders used as a 3:2 carry-save compressor.
//
// Ports:
//   a, b, c  three N-bit addend rows of equal weight.
//   sum      bitwise sum row (a ^ b ^ c).
//   carry    majority row already shifted up one column; the carry out of
//            the top column is dropped because the product is only kept
//            modulo 2^N.
module wallace_csa_row
  import wallace_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  assign sum = a ^ b ^ c;

  assign carry = {(a[N-2:0] & b[N-2:0]) |
                  (a[N-2:0] & c[N-2:0]) |
                  (b[N-2:0] & c[N-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier, unsigned or
// two's-complement per operation, with a pass-through tag.
//
// Stages:
//   S1  partial-product rows (plain AND array, or Baugh-Wooley in signed mode)
//   S2  Wallace tree of 3:2 rows down to a registered sum/carry pair
//   S3  carry-propagate add into the output register
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid, in_ready     operand handshake
//   in_x, in_y             multiplicand, multiplier (WIDTH bits)
//   in_signed              1: both operands two's complement, 0: unsigned
//   in_tag                 opaque ID returned with the result
//   out_valid, out_ready   result handshake
//   out_p                  2*WIDTH-bit exact product
//   out_tag                tag of the operation that produced out_p
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Operand fields are sampled only on an input transfer. While
// out_valid is high and out_ready low, out_p/out_tag hold. in_ready depends
// on out_ready and the stage valid bits only, never on in_valid.
//
// Parameters: WIDTH 4..32, TAG_W 1..16.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int P      = 2 * WIDTH;
  // WIDTH partial-product rows plus one correction row (zero when unsigned).
  localparam int ROWS   = WIDTH + 1;
  localparam int LEVELS = wallace_levels(ROWS);
  localparam logic [P-1:0] BW_CONST = P'(bw_const(WIDTH));

  // ---------------------------------------------------------------------
  // Stage occupancy and flow control
  // ---------------------------------------------------------------------
  logic s1_vld, s2_vld, s3_vld;
  logic s1_ld, s2_ld, s3_ld;

  // A stage may load when it is empty or its content leaves on this edge.
  // Evaluating from the output back lets empty downstream stages absorb
  // data even while out_ready is low.
  assign s3_ld = !s3_vld || out_ready;
  assign s2_ld = !s2_vld || s3_ld;
  assign s1_ld = !s1_vld || s2_ld;

  assign in_ready  = s1_ld;
  assign out_valid = s3_vld;

  // ---------------------------------------------------------------------
  // S1: partial-product generation
  // ---------------------------------------------------------------------
  logic [P-1:0]     pp_nxt [ROWS];
  logic [P-1:0]     s1_pp  [ROWS];
  logic [TAG_W-1:0] s1_tag;

  // In signed mode the terms that mix exactly one sign bit are inverted;
  // the sign*sign term keeps its positive weight.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      pp_nxt[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_nxt[i][i+j] = (in_x[j] & in_y[i]) ^
                         (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp_nxt[WIDTH] = in_signed ? BW_CONST : '0;
  end

  // ---------------------------------------------------------------------
  // S2: Wallace reduction (combinational tree on the S1 rows)
  // ---------------------------------------------------------------------
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN  = wallace_rows_at(ROWS, l);
    localparam int N_GRP = N_IN / 3;
    localparam int N_OUT = 2 * N_GRP + (N_IN % 3);

    logic [P-1:0] rin  [N_IN];
    logic [P-1:0] rout [N_OUT];

    if (l == 0) begin : g_src
      for (genvar k = 0; k < N_IN; k++) begin : g_row
        assign rin[k] = s1_pp[k];
      end
    end else begin : g_src
      for (genvar k = 0; k < N_IN; k++) begin : g_row
        assign rin[k] = g_lvl[l-1].rout[k];
      end
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_csa
      wallace_csa_row #(.N(P)) u_csa (
        .a     (rin[3*g]),
        .b     (rin[3*g+1]),
        .c     (rin[3*g+2]),
        .sum   (rout[2*g]),
        .carry (rout[2*g+1])
      );
    end

    for (genvar r = 0; r < N_IN % 3; r++) begin : g_pass
      assign rout[2*N_GRP + r] = rin[3*N_GRP + r];
    end
  end

  logic [P-1:0]     tree_sum, tree_carry;
  logic [P-1:0]     s2_sum, s2_carry;
  logic [TAG_W-1:0] s2_tag;

  assign tree_sum   = g_lvl[LEVELS-1].rout[0];
  assign tree_carry = g_lvl[LEVELS-1].rout[1];

  // ---------------------------------------------------------------------
  // Datapath registers without reset: they are only observed through a
  // set valid bit, so their power-up contents never matter.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (in_valid && s1_ld) begin
      s1_pp  <= pp_nxt;
      s1_tag <= in_tag;
    end
    if (s1_vld && s2_ld) begin
      s2_sum   <= tree_sum;
      s2_carry <= tree_carry;
      s2_tag   <= s1_tag;
    end
  end

  // ---------------------------------------------------------------------
  // Valid bits and S3 (carry-propagate add into the visible result)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      out_p   <= '0;
      out_tag <= '0;
    end else begin
      if (s1_ld) s1_vld <= in_valid;
      if (s2_ld) s2_vld <= s1_vld;
      if (s3_ld) s3_vld <= s2_vld;
      if (s2_vld && s3_ld) begin
        out_p   <= s2_sum + s2_carry;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed table vectors and multi-cycle corner
// sequences on an 8-bit instance, then randomized traffic on 8, 5 and 16-bit
// instances scored against an arithmetic reference multiply.
module tb_wallace_mult_pipe;
  import wallace_pkg::*;

  localparam int N_RND = 10000;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------
  // Counters and shared helpers
  // ---------------------------------------------------------------------
  int   n_vec = 0;
  int   n_err = 0;
  logic rnd_go = 1'b0;
  int   rnd_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input logic s);
    longint xv, yv, prod;
    xv = longint'(x);
    yv = longint'(y);
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    prod = xv * yv;
    return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // ---------------------------------------------------------------------
  // Directed DUT (WIDTH=8, TAG_W=4)
  // ---------------------------------------------------------------------
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_x, in_y;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_p;
  logic [15:0] cur_exp;

  wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        s;
    logic [3:0]  tag;
    logic [15:0] p;
  } vec_t;

  vec_t tbl [11];

  // Scoreboard for the directed DUT: {tag, product} in acceptance order.
  logic [19:0] exp_q [$];
  int          out_cyc_log [$];
  int          acc_cyc;

  always @(negedge clk) begin : mon
    logic [19:0] e;
    #1;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL d_extra: got unexpected result 0x%0h tag %0d, required none", out_p, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("d_prod", 64'(out_p), 64'(e[15:0]));
          check("d_tag", 64'(out_tag), 64'(e[19:16]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_tag, cur_exp});
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_x      = v.x;
    in_y      = v.y;
    in_signed = v.s;
    in_tag    = v.tag;
    cur_exp   = v.p;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      drive(v);
      #1;
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #2;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------
  // Random instances: WIDTH 8, 5, 16
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < 3; k++) begin : g_rnd
    localparam int W = (k == 0) ? 8 : ((k == 1) ? 5 : 16);

    logic             r_iv, r_ir, r_s, r_ov, r_or;
    logic [W-1:0]     r_x, r_y;
    logic [3:0]       r_tag, r_otag;
    logic [2*W-1:0]   r_p;
    logic [2*W+3:0]   exp_q [$];

    wallace_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (r_iv),
      .in_ready  (r_ir),
      .in_x      (r_x),
      .in_y      (r_y),
      .in_signed (r_s),
      .in_tag    (r_tag),
      .out_valid (r_ov),
      .out_ready (r_or),
      .out_p     (r_p),
      .out_tag   (r_otag)
    );

    task automatic pop_check();
      logic [2*W+3:0] e;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rnd_w%0d_extra: got unexpected result 0x%0h, required none", W, r_p);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rnd_w%0d_prod", W), 64'(r_p), 64'(e[2*W-1:0]));
        check($sformatf("rnd_w%0d_tag", W), 64'(r_otag), 64'(e[2*W+3:2*W]));
      end
    endtask

    initial begin : drv
      int             n;
      logic [2*W-1:0] pm;
      r_iv = 1'b0; r_x = '0; r_y = '0; r_s = 1'b0; r_tag = '0; r_or = 1'b0;
      n = 0;
      wait (rnd_go);
      while (n < N_RND) begin
        @(negedge clk);
        r_iv  = ($urandom_range(0, 3) != 0);
        r_x   = W'($urandom);
        r_y   = W'($urandom);
        r_s   = 1'($urandom_range(0, 1));
        r_tag = 4'($urandom);
        r_or  = ($urandom_range(0, 3) != 0);
        #1;
        if (r_ov && r_or) pop_check();
        if (r_iv && r_ir) begin
          pm = (2*W)'(ref_mul(32'(r_x), 32'(r_y), W, r_s));
          exp_q.push_back({r_tag, pm});
          n++;
        end
      end
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
        @(negedge clk);
        r_iv = 1'b0;
        r_or = 1'b1;
        #1;
        if (r_ov) pop_check();
      end
      check($sformatf("rnd_w%0d_drain", W), 64'(exp_q.size()), 64'd0);
      rnd_done++;
    end
  end

  // ---------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------
  initial begin : main
    int first_acc;

    tbl[0]  = '{8'h0F, 8'h0F, 1'b0, 4'd3,  16'h00E1};
    tbl[1]  = '{8'hFF, 8'hFF, 1'b0, 4'd1,  16'hFE01};
    tbl[2]  = '{8'hFF, 8'h01, 1'b1, 4'd2,  16'hFFFF};
    tbl[3]  = '{8'h80, 8'h80, 1'b1, 4'd4,  16'h4000};
    tbl[4]  = '{8'h80, 8'h7F, 1'b1, 4'd5,  16'hC080};
    tbl[5]  = '{8'h7F, 8'h7F, 1'b1, 4'd6,  16'h3F01};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 4'd7,  16'h4000};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b1, 4'd8,  16'h0001};
    tbl[8]  = '{8'h12, 8'h34, 1'b0, 4'd9,  16'h03A8};
    tbl[9]  = '{8'hF6, 8'h05, 1'b1, 4'd10, 16'hFFCE};
    tbl[10] = '{8'h00, 8'hAB, 1'b1, 4'd11, 16'h0000};

    in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b0; cur_exp = '0; acc_cyc = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Table burst: back-to-back, mixed modes, latency and spacing.
    out_ready = 1'b1;
    out_cyc_log.delete();
    first_acc = 0;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i]);
      if (i == 0) first_acc = acc_cyc;
    end
    drain();
    check("burst_count", 64'(out_cyc_log.size()), 64'd11);
    check("latency", 64'(out_cyc_log[0] - first_acc), 64'(LATENCY));
    for (int i = 1; i < out_cyc_log.size(); i++) begin
      check("b2b_gap", 64'(out_cyc_log[i] - out_cyc_log[i-1]), 64'd1);
    end

    // Backpressure: five operations with the consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    out_cyc_log.delete();
    send(tbl[0]);
    send(tbl[1]);
    send(tbl[2]);
    drive(tbl[3]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold_p", 64'(out_p), 64'(tbl[0].p));
      check("bp_hold_tag", 64'(out_tag), 64'(tbl[0].tag));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_reopen", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(tbl[4]);
    drain();
    check("bp_count", 64'(out_cyc_log.size()), 64'd5);

    // Bubble collapse: one op, two idle cycles, two more ops, all stalled.
    @(negedge clk);
    out_ready = 1'b0;
    send(tbl[5]);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("bub_in_ready", 64'(in_ready), 64'd1);
    end
    send(tbl[6]);
    send(tbl[7]);
    @(negedge clk);
    #1;
    check("bub_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("bub_out_valid", 64'(out_valid), (c < 3) ? 64'd1 : 64'd0);
    end
    drain();

    // Reset with three operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(tbl[8]);
    send(tbl[9]);
    send(tbl[10]);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_rel_in_ready", 64'(in_ready), 64'd1);
    check("rst_rel_out_p", 64'(out_p), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic on the three widths.
    rnd_go = 1'b1;
    for (int c = 0; c < 60000 && rnd_done < 3; c++) @(negedge clk);
    check("rnd_finished", 64'(rnd_done), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
